// File: rtl/ram_block_fifo_ctrl.sv
// Pointer and flow-control front end that runs an async-read RAM array as a FIFO.
// Capacity is MEM_DEPTH RAM entries plus one registered output entry.
module ram_block_fifo_ctrl #(
   parameter int MEM_DEPTH  = 1024,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [ADDR_WIDTH:0]   fill_level
);

   localparam logic [ADDR_WIDTH:0]   DEPTH   = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PTR_MAX = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   ram_count;
   logic                  push;
   logic                  load;

   // Ready looks only at the registered count, never at a same-cycle pop.
   assign in_ready    = !rst && !flush && (ram_count < DEPTH);
   assign push        = in_valid && in_ready;
   assign load        = (ram_count != '0) && (!out_valid || out_ready);

   assign ram_wr_en   = push;
   assign ram_wr_addr = wr_ptr;
   assign ram_wr_data = in_data;
   assign ram_rd_addr = rd_ptr;
   assign fill_level  = ram_count + (ADDR_WIDTH+1)'(out_valid);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_count <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         // Depth need not be a power of two, so wrap on an explicit compare.
         if (push)
            wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PTR_ONE;

         if (load) begin
            rd_ptr    <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PTR_ONE;
            out_data  <= ram_rd_data;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (push && !load)
            ram_count <= ram_count + CNT_ONE;
         else if (load && !push)
            ram_count <= ram_count - CNT_ONE;
      end
   end

endmodule
